mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 39 +++
 rtl/mem_access_ctrl.sv | 61 ++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-bus types and the memory-stage/data-bus port bundle
package mem_access_pkg;
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

interface mem_access_ctrl_if;
  import mem_access_pkg::*;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        flush;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_misalign;
  logic        stall;
  modport slave (input req_valid, req_addr, req_size, req_strobe, req_data, flush, dresp,
                 output dreq, resp_valid, resp_data, resp_misalign, stall);
  modport master (output req_valid, req_addr, req_size, req_strobe, req_data, flush, dresp,
                  input dreq, resp_valid, resp_data, resp_misalign, stall);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-access-at-a-time data-bus controller with flush draining and alignment check
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic        mis_q, mis_d;
  logic        aligned, accept, take, data_ok;
  always_comb begin
    data_ok  = bus.dresp.data_ok;
    aligned  = !CHECK_ALIGN ||
               (bus.req_size == MSIZE2 ? !bus.req_addr[0] :
                bus.req_size == MSIZE4 ? bus.req_addr[1:0] == 2'b0 :
                bus.req_size == MSIZE8 ? bus.req_addr[2:0] == 3'b0 : 1'b1);
    accept   = state_q == IDLE && bus.req_valid && !bus.flush;
    take     = accept && aligned;
    state_d  = state_q == IDLE  ? (accept ? (aligned ? REQ : DONE) : IDLE) :
               state_q == REQ   ? (data_ok ? (bus.flush ? IDLE : DONE) : (bus.flush ? DRAIN : REQ)) :
               state_q == DRAIN ? (data_ok ? IDLE : DRAIN) : IDLE;
    addr_d   = take ? bus.req_addr : addr_q;
    size_d   = take ? bus.req_size : size_q;
    strobe_d = take ? bus.req_strobe : strobe_q;
    data_d   = take ? bus.req_data : data_q;
    mis_d    = accept ? !aligned : mis_q;
    // a flush coinciding with data_ok discards the beat, so resp_data keeps its old value
    rdata_d  = state_q == REQ && data_ok && !bus.flush ? bus.dresp.data : rdata_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
    end
  end
  assign bus.dreq          = {state_q == REQ || state_q == DRAIN, addr_q, size_q, strobe_q, data_q};
  assign bus.resp_valid    = state_q == DONE && !bus.flush;
  assign bus.resp_misalign = state_q == DONE && !bus.flush && mis_q;
  assign bus.resp_data     = rdata_q;
  assign bus.stall         = (bus.req_valid && state_q != DONE) || state_q == DRAIN;
endmodule
